// File: rtl/clkdiv_seq_pkg.sv
// Shared types and helpers for the CLKDIV bring-up/calibration sequencer.
package clkdiv_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD_RST  = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_CALIB_HI  = 3'd4,
    ST_CALIB_GAP = 3'd5
  } seq_state_t;

  localparam int unsigned RELOCK_W = 8;

  // True when a cycle count fits the shared down-counter: 1..2**cnt_w.
  function automatic bit cycles_in_range(input int unsigned cycles,
                                         input int unsigned cnt_w);
    if (cycles == 0) return 1'b0;
    if (cnt_w >= 32) return 1'b1;
    return cycles <= (32'd1 << cnt_w);
  endfunction

endpackage

// File: rtl/clkdiv_seq_sync_2ff.sv
// Two-flop synchronizer for single-bit CDC inputs, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clkdiv_seq.sv
// CLKDIV bring-up sequencer: lock wait, divider reset hold, settle, and
// req/ack-driven CALIB pulses; any loss of lock restarts the sequence.
module clkdiv_seq
  import clkdiv_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned CALIB_HIGH    = 2,
  parameter int unsigned CALIB_GAP     = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_pll_lock,
  output logic                o_div_resetn,
  output logic                o_div_calib,
  input  logic                i_calib_req,
  output logic                o_calib_ack,
  output logic                o_ready,
  output logic [2:0]          o_seq_state,
  output logic [RELOCK_W-1:0] o_relock_cnt
);

  if (CNT_W < 1 ||
      !cycles_in_range(RST_CYCLES, CNT_W) || !cycles_in_range(SETTLE_CYCLES, CNT_W) ||
      !cycles_in_range(CALIB_HIGH, CNT_W) || !cycles_in_range(CALIB_GAP, CNT_W)) begin : g_bad_params
    $error("clkdiv_seq: cycle parameter outside 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGH_LD   = CNT_W'(CALIB_HIGH - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(CALIB_GAP - 1);

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_lock_s;
  logic                w_lock_lost;
  logic                w_cnt_zero;

  logic                r_div_resetn;
  logic                r_div_calib;
  logic                r_calib_ack;
  logic                r_ready;
  logic [RELOCK_W-1:0] r_relock_cnt;
  logic                w_div_resetn_nxt;
  logic                w_div_calib_nxt;
  logic                w_calib_ack_nxt;
  logic                w_ready_nxt;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_reset),
    .i_d   (i_pll_lock),
    .o_q   (w_lock_s)
  );

  assign w_lock_lost = !w_lock_s && (r_state != ST_WAIT_LOCK);
  assign w_cnt_zero  = (r_cnt == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_lock_lost) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: if (w_lock_s) begin
          w_state_nxt = ST_HOLD_RST;
          w_cnt_nxt   = RST_LD;
        end
        ST_HOLD_RST: if (w_cnt_zero) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = SETTLE_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
        ST_SETTLE: if (w_cnt_zero) begin
          w_state_nxt = ST_READY;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
        // The ack cycle masks the request, so a held req restarts one cycle later.
        ST_READY: if (i_calib_req && !r_calib_ack) begin
          w_state_nxt = ST_CALIB_HI;
          w_cnt_nxt   = HIGH_LD;
        end
        ST_CALIB_HI: if (w_cnt_zero) begin
          w_state_nxt = ST_CALIB_GAP;
          w_cnt_nxt   = GAP_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
        ST_CALIB_GAP: if (w_cnt_zero) begin
          w_state_nxt = ST_READY;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
        default: begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it,
  // so each output flop always matches the state register it accompanies.
  always_comb begin
    w_div_resetn_nxt = 1'b0;
    w_div_calib_nxt  = 1'b0;
    w_ready_nxt      = 1'b0;
    case (w_state_nxt)
      ST_SETTLE:    w_div_resetn_nxt = 1'b1;
      ST_READY: begin
        w_div_resetn_nxt = 1'b1;
        w_ready_nxt      = 1'b1;
      end
      ST_CALIB_HI: begin
        w_div_resetn_nxt = 1'b1;
        w_div_calib_nxt  = 1'b1;
      end
      ST_CALIB_GAP: w_div_resetn_nxt = 1'b1;
      default: ;
    endcase
    w_calib_ack_nxt = (r_state == ST_CALIB_GAP) && (w_state_nxt == ST_READY);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div_resetn <= 1'b0;
      r_div_calib  <= 1'b0;
      r_calib_ack  <= 1'b0;
      r_ready      <= 1'b0;
      r_relock_cnt <= '0;
    end else begin
      r_div_resetn <= w_div_resetn_nxt;
      r_div_calib  <= w_div_calib_nxt;
      r_calib_ack  <= w_calib_ack_nxt;
      r_ready      <= w_ready_nxt;
      if (w_lock_lost && (r_relock_cnt != '1)) begin
        r_relock_cnt <= r_relock_cnt + RELOCK_W'(1);
      end
    end
  end

  assign o_div_resetn = r_div_resetn;
  assign o_div_calib  = r_div_calib;
  assign o_calib_ack  = r_calib_ack;
  assign o_ready      = r_ready;
  assign o_seq_state  = r_state;
  assign o_relock_cnt = r_relock_cnt;

endmodule

// File: tb/tb_clkdiv_seq.sv
// Bench for clkdiv_seq: phase/elapsed-time reference model checked every cycle,
// plus directed scenarios with hand-computed edge timings.
module tb_clkdiv_seq;

  localparam int unsigned RST_CYCLES    = 16;
  localparam int unsigned SETTLE_CYCLES = 64;
  localparam int unsigned CALIB_HIGH    = 2;
  localparam int unsigned CALIB_GAP     = 4;
  localparam int unsigned CNT_W         = 8;

  localparam int P_WAIT = 0, P_HOLD = 1, P_SETTLE = 2, P_READY = 3, P_CHI = 4, P_CGAP = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pll_lock = 1'b0;
  logic       calib_req = 1'b0;
  logic       div_resetn, div_calib, calib_ack, ready;
  logic [2:0] seq_state;
  logic [7:0] relock_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  clkdiv_seq #(
    .RST_CYCLES    (RST_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CALIB_HIGH    (CALIB_HIGH),
    .CALIB_GAP     (CALIB_GAP),
    .CNT_W         (CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_pll_lock   (pll_lock),
    .o_div_resetn (div_resetn),
    .o_div_calib  (div_calib),
    .i_calib_req  (calib_req),
    .o_calib_ack  (calib_ack),
    .o_ready      (ready),
    .o_seq_state  (seq_state),
    .o_relock_cnt (relock_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus cycles spent in it; lock history gives the
  // value seen two edges late.
  int         m_phase, m_el, m_relock;
  bit         m_ack;
  logic [1:0] m_hist;

  function automatic int phase_len(input int p);
    case (p)
      P_HOLD:   return RST_CYCLES;
      P_SETTLE: return SETTLE_CYCLES;
      P_CHI:    return CALIB_HIGH;
      P_CGAP:   return CALIB_GAP;
      default:  return 0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hist = 2'b00; m_phase = P_WAIT; m_el = 0; m_ack = 1'b0; m_relock = 0;
    end else begin
      bit lock_seen, ack_was, done;
      lock_seen = m_hist[1];
      m_hist    = {m_hist[0], pll_lock};
      ack_was   = m_ack;
      m_ack     = 1'b0;
      done      = (m_el + 1 >= phase_len(m_phase));
      if (m_phase != P_WAIT && !lock_seen) begin
        m_phase = P_WAIT; m_el = 0;
        if (m_relock < 255) m_relock++;
      end else begin
        case (m_phase)
          P_WAIT:   if (lock_seen) begin m_phase = P_HOLD; m_el = 0; end
          P_READY:  if (calib_req && !ack_was) begin m_phase = P_CHI; m_el = 0; end
          default:  if (done) begin
            m_el = 0;
            if (m_phase == P_HOLD) m_phase = P_SETTLE;
            else if (m_phase == P_SETTLE) m_phase = P_READY;
            else if (m_phase == P_CHI) m_phase = P_CGAP;
            else begin m_phase = P_READY; m_ack = 1'b1; end
          end else m_el++;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("seq_state",  seq_state,  m_phase);
      check("div_resetn", div_resetn, (m_phase >= P_SETTLE) ? 1 : 0);
      check("div_calib",  div_calib,  (m_phase == P_CHI) ? 1 : 0);
      check("ready",      ready,      (m_phase == P_READY) ? 1 : 0);
      check("calib_ack",  calib_ack,  m_ack);
      check("relock_cnt", relock_cnt, m_relock);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Lock is already high two edges before HOLD_RST; edge 1 is the first edge after release.
  task automatic powerup_checks();
    tick(18); check("pu_resetn_e18", div_resetn, 0);
    tick(1);  check("pu_resetn_e19", div_resetn, 1);
    check("pu_ready_e19", ready, 0);
    tick(63); check("pu_ready_e82", ready, 0);
    tick(1);  check("pu_ready_e83", ready, 1);
    check("pu_calib_e83", div_calib, 0);
    check("pu_ack_e83", calib_ack, 0);
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit);
    int k = 0;
    while (seq_state !== st && k < limit) begin
      tick(1);
      k++;
    end
    check("wait_state", seq_state, st);
  endtask

  initial begin
    #2;
    reset = 1'b1; pll_lock = 1'b1; cmp_en = 1'b1;
    #1;
    check("rst_state",  seq_state, 0);
    check("rst_resetn", div_resetn, 0);
    check("rst_relock", relock_cnt, 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    powerup_checks();

    // Single calibration: req raised just after edge k.
    calib_req = 1'b1;
    tick(1); check("cal_calib_k1", div_calib, 1); check("cal_ready_k1", ready, 0);
    tick(1); check("cal_calib_k2", div_calib, 1);
    tick(1); check("cal_calib_k3", div_calib, 0);
    tick(3); check("cal_ready_k6", ready, 0); check("cal_ack_k6", calib_ack, 0);
    tick(1); check("cal_ack_k7", calib_ack, 1); check("cal_ready_k7", ready, 1);
    calib_req = 1'b0;
    tick(1); check("cal_ack_k8", calib_ack, 0); check("cal_state_k8", seq_state, P_READY);

    // Back-to-back: req held for 20 cycles.
    tick(1);
    calib_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 7)  check("b2b_ack1", calib_ack, 1);
      if (i == 8)  begin check("b2b_nopulse_after_ack", div_calib, 0); check("b2b_ack_once", calib_ack, 0); end
      if (i == 9)  check("b2b_pulse2", div_calib, 1);
      if (i == 15) check("b2b_ack2", calib_ack, 1);
    end
    calib_req = 1'b0;
    tick(10); check("b2b_idle", seq_state, P_READY);

    // Lock loss during CALIB_HI.
    calib_req = 1'b1;
    tick(1); check("ll_in_hi", seq_state, P_CHI);
    pll_lock = 1'b0;
    tick(3);
    check("ll_state", seq_state, P_WAIT);
    check("ll_resetn", div_resetn, 0);
    check("ll_calib", div_calib, 0);
    check("ll_ready", ready, 0);
    check("ll_relock", relock_cnt, 1);
    check("ll_ack", calib_ack, 0);
    calib_req = 1'b0;
    tick(5);
    pll_lock = 1'b1;
    powerup_checks();

    // Saturation of the relock counter.
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0; tick(3);
      pll_lock = 1'b1; tick(3);
    end
    check("sat_relock", relock_cnt, 255);
    wait_state(3'(P_READY), 200);

    // Glitch between edges: never sampled.
    #2 pll_lock = 1'b0;
    #3 pll_lock = 1'b1;
    tick(4);
    check("glitch_none_state", seq_state, P_READY);
    check("glitch_none_relock", relock_cnt, 255);

    // Glitch spanning an edge: one clean restart.
    #7 pll_lock = 1'b0;
    #4 pll_lock = 1'b1;
    tick(2); check("glitch_restart", seq_state, P_WAIT);
    tick(1); check("glitch_hold", seq_state, P_HOLD);

    // Async reset while in SETTLE.
    wait_state(3'(P_SETTLE), 100);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_resetn", div_resetn, 0);
    check("areset_ready", ready, 0);
    check("areset_state", seq_state, 0);
    check("areset_relock", relock_cnt, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    powerup_checks();

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
